// File: rtl/pump_controller_if.sv
// pump_controller_if: command inputs and status outputs of the irrigation pump controller
interface pump_controller_if;
  logic       start;
  logic [7:0] irrigation_time;
  logic       rain_present;
  logic       manual_stop;
  logic       pump_on;
  logic       busy;
  logic [7:0] remaining_time;
  logic       done;
  logic       aborted;
  logic       rejected;
  logic [1:0] state;
  modport master (
    output start, irrigation_time, rain_present, manual_stop,
    input  pump_on, busy, remaining_time, done, aborted, rejected, state
  );
  modport slave (
    input  start, irrigation_time, rain_present, manual_stop,
    output pump_on, busy, remaining_time, done, aborted, rejected, state
  );
endinterface

// File: rtl/pump_controller.sv
// pump_controller: timed pump run with rain/operator abort and enforced cooldown
module pump_controller #(
  parameter int         TICKS_PER_SEC = 50000000,
  parameter logic [7:0] MAX_RUN_SEC   = 8'd120,
  parameter logic [7:0] MIN_OFF_SEC   = 8'd60
) (
  input logic clk,
  input logic reset,
  pump_controller_if.slave bus
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COOLDOWN = 2'd2} state_t;
  state_t state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic pump_on_q, done_q, done_d, aborted_q, aborted_d, rejected_q, rejected_d;
  logic tick, accept;
  logic [7:0] run_secs;
  assign tick = presc_q == PW'(TICKS_PER_SEC - 1);
  assign accept = !bus.rain_present && !bus.manual_stop && bus.irrigation_time != 8'd0;
  assign run_secs = (bus.irrigation_time > MAX_RUN_SEC) ? MAX_RUN_SEC : bus.irrigation_time;
  // next state, countdown and event pulses; aborts take precedence over a final tick
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    presc_d = '0;
    done_d = 1'b0;
    aborted_d = 1'b0;
    rejected_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && accept) begin
          state_d = RUN;
          rem_d = run_secs;
        end
        rejected_d = bus.start && !accept;
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (bus.rain_present || bus.manual_stop) begin
          state_d = COOLDOWN;
          rem_d = MIN_OFF_SEC;
          presc_d = '0;
          aborted_d = 1'b1;
        end else if (rem_q <= 8'd1 && (tick || rem_q == 8'd0)) begin
          state_d = COOLDOWN;
          rem_d = MIN_OFF_SEC;
          presc_d = '0;
          done_d = 1'b1;
        end else begin
          rem_d = tick ? rem_q - 8'd1 : rem_q;
          rejected_d = bus.start;
        end
      end
      COOLDOWN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        rejected_d = bus.start;
        if (rem_q <= 8'd1 && (tick || rem_q == 8'd0)) begin
          state_d = IDLE;
          rem_d = 8'd0;
          presc_d = '0;
        end else begin
          rem_d = tick ? rem_q - 8'd1 : rem_q;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d = 8'd0;
      end
    endcase
  end
  // state and registered outputs; reset clears everything with no cooldown
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q <= 8'd0;
      presc_q <= '0;
      pump_on_q <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      presc_q <= presc_d;
      pump_on_q <= state_d == RUN;
      done_q <= done_d;
      aborted_q <= aborted_d;
      rejected_q <= rejected_d;
    end
  end
  assign bus.pump_on = pump_on_q;
  assign bus.busy = state_q != IDLE;
  assign bus.remaining_time = rem_q;
  assign bus.done = done_q;
  assign bus.aborted = aborted_q;
  assign bus.rejected = rejected_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_pump_controller.sv
// tb_pump_controller: directed and random checks against an elapsed-time reference model
module tb_pump_controller;
  localparam int T = 4;
  localparam int MAXS = 10;
  localparam int MINS = 2;
  logic clk = 1'b0;
  logic reset;
  pump_controller_if bus ();
  pump_controller #(.TICKS_PER_SEC(T), .MAX_RUN_SEC(8'(MAXS)), .MIN_OFF_SEC(8'(MINS))) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode = 0;
  int m_secs = 0;
  int m_k = 0;
  bit m_done, m_ab, m_rej;
  int pump_cnt = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(bit s, int it, bit rn, bit ms, bit rs = 1'b0);
    int exp_rem;
    bus.start = s;
    bus.irrigation_time = 8'(it);
    bus.rain_present = rn;
    bus.manual_stop = ms;
    reset = rs;
    @(posedge clk);
    m_done = 1'b0;
    m_ab = 1'b0;
    m_rej = 1'b0;
    if (rs) begin
      m_mode = 0; m_k = 0; m_secs = 0;
    end else if (m_mode == 0) begin
      if (s && !rn && !ms && it != 0) begin
        m_mode = 1; m_secs = (it > MAXS) ? MAXS : it; m_k = 0;
      end else m_rej = s;
    end else if (m_mode == 1) begin
      if (rn || ms) begin
        m_mode = 2; m_secs = MINS; m_k = 0; m_ab = 1'b1;
      end else if (m_k + 1 == m_secs * T) begin
        m_mode = 2; m_secs = MINS; m_k = 0; m_done = 1'b1;
      end else begin
        m_k++; m_rej = s;
      end
    end else begin
      m_rej = s;
      if (m_secs == 0 || m_k + 1 == m_secs * T) begin
        m_mode = 0; m_k = 0; m_secs = 0;
      end else m_k++;
    end
    #1;
    exp_rem = (m_mode == 0) ? 0 : m_secs - m_k / T;
    if (bus.pump_on === 1'b1) pump_cnt++;
    chk("state", 32'(bus.state), 32'(m_mode));
    chk("remaining_time", 32'(bus.remaining_time), 32'(exp_rem));
    chk("pump_on", 32'(bus.pump_on), 32'(m_mode == 1));
    chk("busy", 32'(bus.busy), 32'(m_mode != 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("aborted", 32'(bus.aborted), 32'(m_ab));
    chk("rejected", 32'(bus.rejected), 32'(m_rej));
  endtask
  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    pump_cnt = 0;
    step(1, 3, 0, 0);
    chk("run3_rem_entry", 32'(bus.remaining_time), 32'd3);
    repeat (11) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("run3_done", 32'(bus.done), 32'd1);
    repeat (7) step(0, 0, 0, 0);
    chk("run3_busy_before_idle", 32'(bus.busy), 32'd1);
    step(0, 0, 0, 0);
    chk("run3_busy_idle", 32'(bus.busy), 32'd0);
    chk("run3_pump_cycles", 32'(pump_cnt), 32'd12);
    pump_cnt = 0;
    step(1, 45, 0, 0);
    chk("clamp_rem", 32'(bus.remaining_time), 32'd10);
    repeat (60) step(0, 0, 0, 0);
    chk("clamp_pump_cycles", 32'(pump_cnt), 32'd40);
    pump_cnt = 0;
    step(1, 0, 0, 0);
    chk("zero_rejected", 32'(bus.rejected), 32'd1);
    step(0, 0, 0, 0);
    step(1, 5, 1, 0);
    chk("rain_rejected", 32'(bus.rejected), 32'd1);
    chk("rain_state", 32'(bus.state), 32'd0);
    step(1, 5, 1, 0);
    chk("rain_rejected_held", 32'(bus.rejected), 32'd1);
    chk("rejects_no_pump", 32'(pump_cnt), 32'd0);
    step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    repeat (6) step(0, 9, 0, 0);
    step(0, 0, 1, 0);
    chk("rain_abort_pump", 32'(bus.pump_on), 32'd0);
    chk("rain_abort_pulse", 32'(bus.aborted), 32'd1);
    chk("rain_abort_nodone", 32'(bus.done), 32'd0);
    step(1, 4, 0, 0);
    chk("cooldown_reject", 32'(bus.rejected), 32'd1);
    repeat (6) step(0, 0, 1, 1);
    chk("cooldown_held", 32'(bus.state), 32'd2);
    step(0, 0, 0, 0);
    chk("cooldown_8_cycles", 32'(bus.state), 32'd0);
    step(1, 2, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("final_tick_abort", 32'(bus.aborted), 32'd1);
    chk("final_tick_nodone", 32'(bus.done), 32'd0);
    repeat (8) step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("reset_pump", 32'(bus.pump_on), 32'd0);
    chk("reset_rem", 32'(bus.remaining_time), 32'd0);
    step(1, 4, 0, 0);
    chk("reset_restart", 32'(bus.state), 32'd1);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0,
           (($urandom % 10) == 0) ? int'($urandom_range(11, 255)) : int'($urandom_range(0, 12)),
           ($urandom % 40) == 0, ($urandom % 60) == 0, ($urandom % 300) == 0);
      chk("exclusive", 32'(int'(bus.done) + int'(bus.aborted) + int'(bus.rejected) <= 1), 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
